// File: rtl/ysyx_22040088_lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, op-field
// layout, access-size codes and the natural-alignment test.
package ysyx_22040088_lsu_pkg;

    localparam int XLEN        = 64;
    localparam int RD_W        = 5;

    // Bit positions inside the 4-bit memory opcode
    localparam int OP_STORE    = 3;
    localparam int OP_UNSIGNED = 2;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_RSP,
        WB
    } state_e;

    function automatic logic misaligned(size_e size, logic [2:0] off);
        case (size)
            SZ_H:    return off[0];
            SZ_W:    return |off[1:0];
            SZ_D:    return |off;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_22040088_lsu_if.sv
// EXU-side op channel, data-bus request/response and writeback channel of the LSU.
// The slave modport is the LSU itself; the master modport is its environment.
interface ysyx_22040088_lsu_if;
    import ysyx_22040088_lsu_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [3:0]      in_op;
    logic [XLEN-1:0] in_addr;
    logic [XLEN-1:0] in_wdata;
    logic [RD_W-1:0] in_rd;

    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [XLEN-1:0] mem_req_addr;
    logic            mem_req_we;
    logic [7:0]      mem_req_wstrb;
    logic [XLEN-1:0] mem_req_wdata;
    logic            mem_rsp_valid;
    logic [XLEN-1:0] mem_rsp_rdata;

    logic            wb_valid;
    logic            wb_ready;
    logic            wb_we;
    logic [RD_W-1:0] wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            wb_misalign;

    modport slave (
        input  in_valid, in_op, in_addr, in_wdata, in_rd,
        output in_ready,
        output mem_req_valid, mem_req_addr, mem_req_we, mem_req_wstrb, mem_req_wdata,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
        output wb_valid, wb_we, wb_rd, wb_data, wb_misalign,
        input  wb_ready
    );

    modport master (
        output in_valid, in_op, in_addr, in_wdata, in_rd,
        input  in_ready,
        input  mem_req_valid, mem_req_addr, mem_req_we, mem_req_wstrb, mem_req_wdata,
        output mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
        input  wb_valid, wb_we, wb_rd, wb_data, wb_misalign,
        output wb_ready
    );

endinterface

// File: rtl/ysyx_22040088_lsu_align.sv
// Combinational lane logic: store data shift and byte strobes, and load byte
// select with sign/zero extension.
module ysyx_22040088_lsu_align
    import ysyx_22040088_lsu_pkg::*;
(
    input  size_e           st_size,
    input  logic [2:0]      st_off,
    input  logic [XLEN-1:0] st_wdata,
    output logic [7:0]      st_wstrb,
    output logic [XLEN-1:0] st_data,

    input  size_e           ld_size,
    input  logic            ld_unsigned,
    input  logic [2:0]      ld_off,
    input  logic [XLEN-1:0] ld_rdata,
    output logic [XLEN-1:0] ld_data
);

    logic [XLEN-1:0] ld_shifted;

    always_comb begin
        st_data  = st_wdata << {st_off, 3'b000};
        st_wstrb = 8'hFF;
        case (st_size)
            SZ_B:    st_wstrb = 8'h01 << st_off;
            SZ_H:    st_wstrb = 8'h03 << st_off;
            SZ_W:    st_wstrb = 8'h0F << st_off;
            default: st_wstrb = 8'hFF;
        endcase
    end

    // A D-size load has no extension, so the unsigned bit is irrelevant there
    always_comb begin
        ld_shifted = ld_rdata >> {ld_off, 3'b000};
        ld_data    = ld_shifted;
        case (ld_size)
            SZ_B: ld_data = ld_unsigned ? {{(XLEN-8){1'b0}}, ld_shifted[7:0]}
                                        : {{(XLEN-8){ld_shifted[7]}}, ld_shifted[7:0]};
            SZ_H: ld_data = ld_unsigned ? {{(XLEN-16){1'b0}}, ld_shifted[15:0]}
                                        : {{(XLEN-16){ld_shifted[15]}}, ld_shifted[15:0]};
            SZ_W: ld_data = ld_unsigned ? {{(XLEN-32){1'b0}}, ld_shifted[31:0]}
                                        : {{(XLEN-32){ld_shifted[31]}}, ld_shifted[31:0]};
            default: ld_data = ld_shifted;
        endcase
    end

endmodule

// File: rtl/ysyx_22040088_lsu.sv
// Multi-cycle load/store unit: accepts one EXU memory op at a time, runs it over
// a valid/ready data bus and holds the extended result until writeback takes it.
module ysyx_22040088_lsu
    import ysyx_22040088_lsu_pkg::*;
(
    input logic clk,
    input logic rst,
    ysyx_22040088_lsu_if.slave bus
);

    state_e state, state_nxt;

    logic [3:0]      op_q;
    logic [2:0]      off_q;
    logic [XLEN-1:0] req_addr_q;
    logic            req_we_q;
    logic [7:0]      req_wstrb_q;
    logic [XLEN-1:0] req_wdata_q;
    logic            wb_we_q;
    logic [RD_W-1:0] wb_rd_q;
    logic [XLEN-1:0] wb_data_q;
    logic            wb_misalign_q;

    logic            in_ready, mem_req_valid, wb_valid;
    logic            accept, in_misaligned, rsp_take;
    logic [7:0]      st_wstrb;
    logic [XLEN-1:0] st_data, ld_data;

    assign accept        = (state == IDLE) && bus.in_valid;
    assign rsp_take      = (state == WAIT_RSP) && bus.mem_rsp_valid;
    assign in_misaligned = misaligned(size_e'(bus.in_op[1:0]), bus.in_addr[2:0]);

    ysyx_22040088_lsu_align u_align (
        .st_size     (size_e'(bus.in_op[1:0])),
        .st_off      (bus.in_addr[2:0]),
        .st_wdata    (bus.in_wdata),
        .st_wstrb    (st_wstrb),
        .st_data     (st_data),
        .ld_size     (size_e'(op_q[1:0])),
        .ld_unsigned (op_q[OP_UNSIGNED]),
        .ld_off      (off_q),
        .ld_rdata    (bus.mem_rsp_rdata),
        .ld_data     (ld_data)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt     = state;
        in_ready      = 1'b0;
        mem_req_valid = 1'b0;
        wb_valid      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) state_nxt = in_misaligned ? WB : REQ;
            end
            REQ: begin
                mem_req_valid = 1'b1;
                if (bus.mem_req_ready) state_nxt = WAIT_RSP;
            end
            WAIT_RSP: if (bus.mem_rsp_valid) state_nxt = WB;
            WB: begin
                wb_valid = 1'b1;
                if (bus.wb_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request fields are captured at accept, so they are stable under backpressure
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q          <= '0;
            off_q         <= '0;
            req_addr_q    <= '0;
            req_we_q      <= 1'b0;
            req_wstrb_q   <= '0;
            req_wdata_q   <= '0;
            wb_we_q       <= 1'b0;
            wb_rd_q       <= '0;
            wb_data_q     <= '0;
            wb_misalign_q <= 1'b0;
        end else if (accept) begin
            op_q          <= bus.in_op;
            off_q         <= bus.in_addr[2:0];
            req_addr_q    <= {bus.in_addr[XLEN-1:3], 3'b000};
            req_we_q      <= bus.in_op[OP_STORE];
            req_wstrb_q   <= st_wstrb;
            req_wdata_q   <= st_data;
            wb_we_q       <= 1'b0;
            wb_rd_q       <= bus.in_rd;
            wb_data_q     <= '0;
            wb_misalign_q <= in_misaligned;
        end else if (rsp_take) begin
            wb_we_q   <= ~op_q[OP_STORE];
            wb_data_q <= op_q[OP_STORE] ? '0 : ld_data;
        end
    end

    assign bus.in_ready      = in_ready;
    assign bus.mem_req_valid = mem_req_valid;
    assign bus.mem_req_addr  = req_addr_q;
    assign bus.mem_req_we    = req_we_q;
    assign bus.mem_req_wstrb = req_wstrb_q;
    assign bus.mem_req_wdata = req_wdata_q;
    assign bus.wb_valid      = wb_valid;
    assign bus.wb_we         = wb_we_q;
    assign bus.wb_rd         = wb_rd_q;
    assign bus.wb_data       = wb_data_q;
    assign bus.wb_misalign   = wb_misalign_q;

endmodule

// File: tb/tb_ysyx_22040088_lsu.sv
// Directed vector bench for the LSU: a table of ops with hand-computed bus and
// writeback values, plus backpressure and mid-operation reset sequences.
module tb_ysyx_22040088_lsu;

    typedef struct {
        logic [3:0]  op;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [4:0]  rd;
        logic [63:0] rdata;
        logic        mis;
        logic [63:0] exp_addr;
        logic [7:0]  exp_wstrb;
        logic [63:0] exp_wdata;
        logic        exp_wb_we;
        logic [63:0] exp_wb_data;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    ysyx_22040088_lsu_if bus ();

    ysyx_22040088_lsu dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic check_req(input string tag, input vec_t v);
        check({tag, " req_valid"}, 64'(bus.mem_req_valid), 64'd1);
        check({tag, " req_addr"},  bus.mem_req_addr, v.exp_addr);
        check({tag, " req_we"},    64'(bus.mem_req_we), 64'(v.op[3]));
        check({tag, " in_ready"},  64'(bus.in_ready), 64'd0);
        if (v.op[3]) begin
            check({tag, " req_wstrb"}, 64'(bus.mem_req_wstrb), 64'(v.exp_wstrb));
            check({tag, " req_wdata"}, bus.mem_req_wdata, v.exp_wdata);
        end
    endtask

    task automatic check_wb(input string tag, input vec_t v);
        check({tag, " wb_valid"},    64'(bus.wb_valid), 64'd1);
        check({tag, " wb_we"},       64'(bus.wb_we), 64'(v.exp_wb_we));
        check({tag, " wb_data"},     bus.wb_data, v.exp_wb_data);
        check({tag, " wb_rd"},       64'(bus.wb_rd), 64'(v.rd));
        check({tag, " wb_misalign"}, 64'(bus.wb_misalign), 64'(v.mis));
        check({tag, " wb req_valid"}, 64'(bus.mem_req_valid), 64'd0);
        check({tag, " wb in_ready"}, 64'(bus.in_ready), 64'd0);
    endtask

    // Inputs change and outputs are sampled on the falling edge
    task automatic run_op(input string tag, input vec_t v, input int req_stall, input int wb_stall);
        @(negedge clk);
        check({tag, " idle in_ready"}, 64'(bus.in_ready), 64'd1);
        bus.in_valid      = 1'b1;
        bus.in_op         = v.op;
        bus.in_addr       = v.addr;
        bus.in_wdata      = v.wdata;
        bus.in_rd         = v.rd;
        bus.mem_req_ready = (req_stall == 0);
        bus.wb_ready      = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        if (!v.mis) begin
            check_req(tag, v);
            for (int k = 0; k < req_stall; k++) begin
                @(negedge clk);
                check_req({tag, " stall"}, v);
                if (k == req_stall - 1) bus.mem_req_ready = 1'b1;
            end
            @(negedge clk);
            bus.mem_req_ready = 1'b0;
            check({tag, " wait req_valid"}, 64'(bus.mem_req_valid), 64'd0);
            check({tag, " wait wb_valid"},  64'(bus.wb_valid), 64'd0);
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_rdata = v.rdata;
            @(negedge clk);
            bus.mem_rsp_valid = 1'b0;
            bus.mem_rsp_rdata = '0;
        end
        check_wb(tag, v);
        bus.wb_ready = (wb_stall == 0);
        for (int k = 0; k < wb_stall; k++) begin
            @(negedge clk);
            check_wb({tag, " hold"}, v);
            if (k == wb_stall - 1) bus.wb_ready = 1'b1;
        end
        @(negedge clk);
        bus.wb_ready = 1'b0;
        check({tag, " done wb_valid"}, 64'(bus.wb_valid), 64'd0);
        check({tag, " done in_ready"}, 64'(bus.in_ready), 64'd1);
    endtask

    vec_t vecs[14];
    vec_t bp_vec;
    vec_t post_vec;

    initial begin
        bus.in_valid      = 1'b0;
        bus.in_op         = '0;
        bus.in_addr       = '0;
        bus.in_wdata      = '0;
        bus.in_rd         = '0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_rdata = '0;
        bus.wb_ready      = 1'b0;

        //            op     addr                   wdata                  rd     rdata                  mis   exp_addr               wstrb  exp_wdata              wb_we exp_wb_data
        vecs[0]  = '{4'hA, 64'h0000_0000_8000_0004, 64'h1122_3344_5566_7788, 5'd1,  64'h0,                 1'b0, 64'h0000_0000_8000_0000, 8'hF0, 64'h5566_7788_0000_0000, 1'b0, 64'h0};
        vecs[1]  = '{4'h0, 64'h0000_0000_8000_0003, 64'h0,                 5'd5,  64'h0000_0000_8000_0000, 1'b0, 64'h0000_0000_8000_0000, 8'h00, 64'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FF80};
        vecs[2]  = '{4'h4, 64'h0000_0000_8000_0003, 64'h0,                 5'd6,  64'h0000_0000_8000_0000, 1'b0, 64'h0000_0000_8000_0000, 8'h00, 64'h0, 1'b1, 64'h0000_0000_0000_0080};
        vecs[3]  = '{4'h6, 64'h0000_0000_8000_0004, 64'h0,                 5'd7,  64'hDEAD_BEEF_0000_0001, 1'b0, 64'h0000_0000_8000_0000, 8'h00, 64'h0, 1'b1, 64'h0000_0000_DEAD_BEEF};
        vecs[4]  = '{4'h2, 64'h0000_0000_8000_0004, 64'h0,                 5'd8,  64'hDEAD_BEEF_0000_0001, 1'b0, 64'h0000_0000_8000_0000, 8'h00, 64'h0, 1'b1, 64'hFFFF_FFFF_DEAD_BEEF};
        vecs[5]  = '{4'h1, 64'h0000_0000_8000_0001, 64'h0,                 5'd9,  64'h0,                 1'b1, 64'h0,                 8'h00, 64'h0, 1'b0, 64'h0};
        vecs[6]  = '{4'h8, 64'h0000_0000_8000_0005, 64'h0000_0000_0000_00AB, 5'd10, 64'h0,                 1'b0, 64'h0000_0000_8000_0000, 8'h20, 64'h0000_AB00_0000_0000, 1'b0, 64'h0};
        vecs[7]  = '{4'h9, 64'h0000_0000_8000_0006, 64'h0000_0000_0000_BEEF, 5'd11, 64'h0,                 1'b0, 64'h0000_0000_8000_0000, 8'hC0, 64'hBEEF_0000_0000_0000, 1'b0, 64'h0};
        vecs[8]  = '{4'hB, 64'h0000_0000_8000_0008, 64'h0102_0304_0506_0708, 5'd12, 64'h0,                 1'b0, 64'h0000_0000_8000_0008, 8'hFF, 64'h0102_0304_0506_0708, 1'b0, 64'h0};
        vecs[9]  = '{4'h7, 64'h0000_0000_8000_0010, 64'h0,                 5'd13, 64'h8877_6655_4433_2211, 1'b0, 64'h0000_0000_8000_0010, 8'h00, 64'h0, 1'b1, 64'h8877_6655_4433_2211};
        vecs[10] = '{4'h1, 64'h0000_0000_8000_0006, 64'h0,                 5'd14, 64'h8001_0000_0000_0000, 1'b0, 64'h0000_0000_8000_0000, 8'h00, 64'h0, 1'b1, 64'hFFFF_FFFF_FFFF_8001};
        vecs[11] = '{4'h5, 64'h0000_0000_8000_0006, 64'h0,                 5'd15, 64'h8001_0000_0000_0000, 1'b0, 64'h0000_0000_8000_0000, 8'h00, 64'h0, 1'b1, 64'h0000_0000_0000_8001};
        vecs[12] = '{4'hA, 64'h0000_0000_8000_0002, 64'h1234_5678_9ABC_DEF0, 5'd16, 64'h0,                 1'b1, 64'h0,                 8'h00, 64'h0, 1'b0, 64'h0};
        vecs[13] = '{4'h3, 64'h0000_0000_8000_0004, 64'h0,                 5'd17, 64'h0,                 1'b1, 64'h0,                 8'h00, 64'h0, 1'b0, 64'h0};

        bp_vec   = '{4'h3, 64'h0000_0000_8000_0020, 64'h0, 5'd20, 64'hCAFE_F00D_1234_5678, 1'b0,
                     64'h0000_0000_8000_0020, 8'h00, 64'h0, 1'b1, 64'hCAFE_F00D_1234_5678};
        post_vec = '{4'h3, 64'h0000_0000_8000_0040, 64'h0, 5'd22, 64'h0123_4567_89AB_CDEF, 1'b0,
                     64'h0000_0000_8000_0040, 8'h00, 64'h0, 1'b1, 64'h0123_4567_89AB_CDEF};

        // Reset state
        #1;
        check("rst in_ready",      64'(bus.in_ready), 64'd1);
        check("rst req_valid",     64'(bus.mem_req_valid), 64'd0);
        check("rst req_addr",      bus.mem_req_addr, 64'd0);
        check("rst req_we",        64'(bus.mem_req_we), 64'd0);
        check("rst req_wstrb",     64'(bus.mem_req_wstrb), 64'd0);
        check("rst req_wdata",     bus.mem_req_wdata, 64'd0);
        check("rst wb_valid",      64'(bus.wb_valid), 64'd0);
        check("rst wb_we",         64'(bus.wb_we), 64'd0);
        check("rst wb_rd",         64'(bus.wb_rd), 64'd0);
        check("rst wb_data",       bus.wb_data, 64'd0);
        check("rst wb_misalign",   64'(bus.wb_misalign), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 14; i++) run_op($sformatf("v%0d", i), vecs[i], 0, 0);

        run_op("backpressure", bp_vec, 3, 3);

        // Reset while waiting for the bus response, then a stale response
        @(negedge clk);
        bus.in_valid      = 1'b1;
        bus.in_op         = 4'h3;
        bus.in_addr       = 64'h0000_0000_8000_0030;
        bus.in_wdata      = '0;
        bus.in_rd         = 5'd21;
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("abort req_valid", 64'(bus.mem_req_valid), 64'd1);
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        check("abort wait req_valid", 64'(bus.mem_req_valid), 64'd0);
        rst = 1'b0;
        #1;
        check("abort in_ready",  64'(bus.in_ready), 64'd1);
        check("abort req_addr",  bus.mem_req_addr, 64'd0);
        check("abort wb_valid",  64'(bus.wb_valid), 64'd0);
        check("abort wb_rd",     64'(bus.wb_rd), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_rdata = '0;
        check("stale wb_valid",  64'(bus.wb_valid), 64'd0);
        check("stale wb_data",   bus.wb_data, 64'd0);
        check("stale in_ready",  64'(bus.in_ready), 64'd1);
        check("stale req_valid", 64'(bus.mem_req_valid), 64'd0);

        run_op("post_reset", post_vec, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ysyx_22040088_lsu.md
Name: ysyx_22040088_lsu

Overview:
- Multi-cycle load/store unit directly downstream of the EXU.
- Consumes the EXU's effective address (alu_result), store data (rs2) and memory opcode. Replaces the combinational memory hookup with a valid/ready data-bus handshake.
- Produces aligned, sign/zero-extended load data for register-file writeback, plus a completion and misalignment indication.

Parameters:
- XLEN, 64, data/address width; only 64 is supported.
- RD_W, 5, destination register index width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous assert, active-low (0 = reset). Released synchronously to clk by the top level.
- in_valid  in  1  EXU presents a memory operation.
- in_ready  out  1  LSU accepts an operation (IDLE only).
- in_op  in  4  bit3 = store; bit2 = unsigned load; bits1:0 = size (0 B, 1 H, 2 W, 3 D).
- in_addr  in  XLEN  effective byte address.
- in_wdata  in  XLEN  store data, right-justified.
- in_rd  in  RD_W  load destination register.
- mem_req_valid  out  1  bus request.
- mem_req_ready  in  1  bus accepts request.
- mem_req_addr  out  XLEN  in_addr with bits 2:0 cleared.
- mem_req_we  out  1  1 = write.
- mem_req_wstrb  out  8  byte enables, lane = addr[2:0].
- mem_req_wdata  out  XLEN  store data shifted left by 8*addr[2:0], zero-filled.
- mem_rsp_valid  in  1  read data / write acknowledge.
- mem_rsp_rdata  in  XLEN  aligned 64-bit read data.
- wb_valid  out  1  result available.
- wb_ready  in  1  writeback consumes result.
- wb_we  out  1  1 = write wb_data to wb_rd (loads without error only).
- wb_rd  out  RD_W  destination register.
- wb_data  out  XLEN  extended load data; 0 for stores and errors.
- wb_misalign  out  1  access was not naturally aligned.

Behaviour:
- States: IDLE, REQ, WAIT_RSP, WB. Reset state is IDLE.
- Reset values: all outputs 0 except in_ready = 1. All request and result registers are cleared.
- IDLE:
  - in_ready = 1.
  - On in_valid, latch op/addr/wdata/rd.
  - Misaligned access (H with addr[0]≠0; W with addr[1:0]≠0; D with addr[2:0]≠0) → WB with wb_misalign = 1, wb_we = 0, wb_data = 0. No bus request is issued.
  - Aligned access → REQ.
- REQ:
  - mem_req_valid = 1, driven from registers.
  - Address, we, wstrb and wdata are held stable while mem_req_ready = 0.
  - On mem_req_valid & mem_req_ready → WAIT_RSP.
- WAIT_RSP:
  - Waits for mem_rsp_valid. The bus never responds in the same cycle as its request handshake.
  - Load: select bytes from rdata >> 8*addr[2:0], truncate to size, then sign-extend (bit2 = 0) or zero-extend (bit2 = 1). Register the result as wb_data, set wb_we = 1 → WB.
  - Store: rsp is the acknowledge; wb_we = 0, wb_data = 0 → WB.
- WB:
  - wb_valid = 1. wb_* outputs are held stable until wb_ready.
  - On wb_ready → IDLE.
  - There is no IDLE bypass: one operation is in flight at a time.
- Minimum latency with an immediately ready bus and a 1-cycle response: accept at cycle N, mem_req_valid at N+1, rsp at N+2, wb_valid at N+3. Misaligned access: wb_valid at N+1.
- wstrb by size: B = 0x01<<off; H = 0x03<<off; W = 0x0F<<off; D = 0xFF.
- Unsigned D load behaves as D. Bit2 is ignored for stores.
- mem_rsp_valid outside WAIT_RSP is ignored.
- Asynchronous reset in any state aborts the operation and returns to IDLE. A bus response that arrives later is ignored.
- in_valid while in_ready = 0 is ignored. The EXU holds its request until accepted.

Decomposition:
- Package ysyx_22040088_lsu_pkg holds:
  - state enum (IDLE, REQ, WAIT_RSP, WB);
  - op field positions and size codes (SZ_B/H/W/D);
  - function misaligned(size, off).
- Sub-module ysyx_22040088_lsu_align (combinational) holds:
  - store shift and wstrb generation;
  - load byte select and sign/zero extension.
- The main module contains the FSM and registers only.

Test Plan:
- SW, addr 0x8000_0004, wdata 0x1122_3344_5566_7788, mem_req_ready = 1, rsp after 1 cycle → mem_req_addr 0x8000_0000, wstrb 0xF0, mem_req_wdata 0x5566_7788_0000_0000, we = 1; then wb_valid with wb_we = 0, wb_data 0.
- LB, addr 0x8000_0003, rdata 0x0000_0000_8000_0000 → wb_data 0xFFFF_FFFF_FFFF_FF80, wb_we = 1, wb_rd = in_rd. Same access as LBU → 0x0000_0000_0000_0080.
- LWU, addr 0x8000_0004, rdata 0xDEAD_BEEF_0000_0001 → wb_data 0x0000_0000_DEAD_BEEF. LW at the same address → 0xFFFF_FFFF_DEAD_BEEF.
- LH at addr 0x8000_0001 → no mem_req_valid ever; wb_valid the next cycle with wb_misalign = 1, wb_we = 0.
- Backpressure: hold mem_req_ready = 0 for 3 cycles, then wb_ready = 0 for 3 cycles on LD → mem_req fields and then wb_* fields stay constant; in_ready = 0 throughout; completes exactly once.
- Assert rst = 0 during WAIT_RSP, release, then pulse mem_rsp_valid → outputs reset immediately; stale response produces no wb_valid; a following LD completes normally.
